// File: rtl/quad_step_decoder.sv
// Quadrature A/B/index front end: synchronise, optionally glitch-filter, decode Gray steps
// into one-cycle en/up, load or syn_clr commands. Optional filter: define GLITCH_FILTER_EN.
module quad_step_decoder #(
  parameter int unsigned N           = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILT_LEN    = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         a_in,
  input  logic         b_in,
  input  logic         idx_in,
  input  logic         idx_mode,
  input  logic [N-1:0] preset_val,
  input  logic         err_clr,
  output logic         en_out,
  output logic         up_out,
  output logic         load_out,
  output logic [N-1:0] d_out,
  output logic         syn_clr_out,
  output logic         err_flag
);

`ifdef GLITCH_FILTER_EN
  localparam int unsigned INIT_LEN = SYNC_STAGES + FILT_LEN;
`else
  localparam int unsigned INIT_LEN = SYNC_STAGES;
`endif
  localparam int unsigned INIT_W = $clog2(INIT_LEN + 1);

  if (SYNC_STAGES < 2 || FILT_LEN < 2) begin : g_bad_params
    $error("quad_step_decoder: SYNC_STAGES and FILT_LEN must both be >= 2");
  end

  typedef enum logic {S_INIT, S_TRACK} state_t;

  state_t              state;
  logic [INIT_W-1:0]   init_cnt;
  logic [2:0]          sync_q [SYNC_STAGES];
  logic [2:0]          filt;
  logic [1:0]          prev_ab;
  logic                prev_idx;
  logic                pend_valid;
  logic                pend_up;

  // Bit order everywhere: {a, b, idx}
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(SYNC_STAGES); i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= {a_in, b_in, idx_in};
      for (int i = 1; i < int'(SYNC_STAGES); i++) sync_q[i] <= sync_q[i-1];
    end
  end

`ifdef GLITCH_FILTER_EN
  localparam int unsigned FILT_W = $clog2(FILT_LEN);

  logic [FILT_W-1:0] filt_cnt [3];
  logic [2:0]        filt_q;

  // Filtered bit flips on the FILT_LEN-th consecutive differing sample
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_q <= '0;
      for (int k = 0; k < 3; k++) filt_cnt[k] <= '0;
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (sync_q[SYNC_STAGES-1][k] == filt_q[k]) begin
          filt_cnt[k] <= '0;
        end else if (filt_cnt[k] == FILT_W'(FILT_LEN - 1)) begin
          filt_q[k]   <= sync_q[SYNC_STAGES-1][k];
          filt_cnt[k] <= '0;
        end else begin
          filt_cnt[k] <= filt_cnt[k] + 1'b1;
        end
      end
    end
  end

  assign filt = filt_q;
`else
  assign filt = sync_q[SYNC_STAGES-1];
`endif

  // Position along the up sequence 00->01->11->10
  function automatic logic [1:0] gray_pos(input logic [1:0] ab);
    return {ab[1], ab[1] ^ ab[0]};
  endfunction

  logic [1:0] ab_c;
  logic       idx_c;
  logic [1:0] diff_c;
  logic       step_c;
  logic       step_up_c;
  logic       err_c;
  logic       idx_rise_c;

  assign ab_c       = filt[2:1];
  assign idx_c      = filt[0];
  assign diff_c     = ab_c ^ prev_ab;
  assign step_c     = (diff_c == 2'b01) || (diff_c == 2'b10);
  assign err_c      = (diff_c == 2'b11);
  assign step_up_c  = (gray_pos(ab_c) - gray_pos(prev_ab)) == 2'd1;
  assign idx_rise_c = idx_c & ~prev_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_INIT;
      init_cnt    <= '0;
      prev_ab     <= '0;
      prev_idx    <= 1'b0;
      pend_valid  <= 1'b0;
      pend_up     <= 1'b0;
      en_out      <= 1'b0;
      up_out      <= 1'b0;
      load_out    <= 1'b0;
      syn_clr_out <= 1'b0;
      d_out       <= '0;
      err_flag    <= 1'b0;
    end else begin
      en_out      <= 1'b0;
      load_out    <= 1'b0;
      syn_clr_out <= 1'b0;

      if (state == S_INIT) begin
        if (init_cnt == INIT_W'(INIT_LEN)) begin
          prev_ab  <= ab_c;
          prev_idx <= idx_c;
          state    <= S_TRACK;
        end else begin
          init_cnt <= init_cnt + 1'b1;
        end
      end else begin
        prev_ab  <= ab_c;
        prev_idx <= idx_c;
        // Index wins the cycle; a colliding step waits one cycle in the pending slot
        if (idx_rise_c) begin
          if (idx_mode) begin
            load_out <= 1'b1;
            d_out    <= preset_val;
          end else begin
            syn_clr_out <= 1'b1;
          end
          if (step_c && !pend_valid) begin
            pend_valid <= 1'b1;
            pend_up    <= step_up_c;
          end
        end else if (pend_valid) begin
          en_out     <= 1'b1;
          up_out     <= pend_up;
          pend_valid <= step_c;
          pend_up    <= step_up_c;
        end else if (step_c) begin
          en_out <= 1'b1;
          up_out <= step_up_c;
        end
      end

      if (state == S_TRACK && err_c) err_flag <= 1'b1;
      else if (err_clr)              err_flag <= 1'b0;
    end
  end

endmodule

// File: tb/tb_quad_step_decoder.sv
// Scoreboard bench for quad_step_decoder: stimulus predicts command slots, a monitor checks them.
module tb_quad_step_decoder;
  localparam int unsigned N    = 8;
  localparam int unsigned SYNC = 2;
  localparam int unsigned FILT = 4;
`ifdef GLITCH_FILTER_EN
  localparam int L    = SYNC + FILT + 1;
  localparam int MINH = FILT;
`else
  localparam int L    = SYNC + 1;
  localparam int MINH = 2;
`endif

  logic         clk;
  logic         rst_n;
  logic         a_in, b_in, idx_in, idx_mode, err_clr;
  logic [N-1:0] preset_val;
  logic         en_out, up_out, load_out, syn_clr_out, err_flag;
  logic [N-1:0] d_out;

  quad_step_decoder #(.N(N), .SYNC_STAGES(SYNC), .FILT_LEN(FILT)) dut (
    .clk(clk), .rst_n(rst_n), .a_in(a_in), .b_in(b_in), .idx_in(idx_in),
    .idx_mode(idx_mode), .preset_val(preset_val), .err_clr(err_clr),
    .en_out(en_out), .up_out(up_out), .load_out(load_out), .d_out(d_out),
    .syn_clr_out(syn_clr_out), .err_flag(err_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int           t;
    int           kind;   // 0 step, 1 load, 2 syn_clr
    logic         up;
    logic [N-1:0] d;
  } ev_t;

  ev_t        exp_q[$];
  bit         errset[int];
  bit         clrat[int];
  int         cyc, n_cmp, n_bad, next_free;
  logic [1:0] m_ab;
  logic       m_idx;
  logic       exp_err, last_up;
  bit         mon_en;
  int         gp[4]  = '{0, 1, 3, 2};   // ab value -> position in up sequence
  logic [1:0] abv[4] = '{2'b00, 2'b01, 2'b11, 2'b10};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  // Commands take one slot each; a slot already taken pushes the next command one cycle later
  function automatic int sched(input int t);
    int s;
    s = (t > next_free) ? t : next_free;
    next_free = s + 1;
    return s;
  endfunction

  task automatic model_apply(input logic [1:0] ab, input logic idx, input logic clr, input int c);
    int  t, dlt;
    ev_t e;
    t = c + L;
    if (idx && !m_idx) begin
      e.t = sched(t); e.kind = idx_mode ? 1 : 2; e.up = 1'b0; e.d = preset_val;
      exp_q.push_back(e);
    end
    dlt = (gp[ab] - gp[m_ab] + 4) % 4;
    if (dlt == 1 || dlt == 3) begin
      e.t = sched(t); e.kind = 0; e.up = (dlt == 1); e.d = '0;
      exp_q.push_back(e);
    end else if (dlt == 2) begin
      errset[t] = 1'b1;
    end
    if (clr) clrat[c] = 1'b1;
    m_ab  = ab;
    m_idx = idx;
  endtask

  task automatic cyc_step(input logic [1:0] ab, input logic idx, input logic clr);
    @(posedge clk); #1;
    model_apply(ab, idx, clr, cyc);
    a_in = ab[1]; b_in = ab[0]; idx_in = idx; err_clr = clr;
  endtask

  task automatic hold(input logic [1:0] ab, input logic idx, input int n);
    for (int i = 0; i < n; i++) cyc_step(ab, idx, 1'b0);
  endtask

  task automatic set_cfg(input logic mode, input logic [N-1:0] val);
    hold(m_ab, m_idx, L + 2);
    idx_mode   = mode;
    preset_val = val;
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    mon_en = 1'b0;
    rst_n  = 1'b0;
    err_clr = 1'b0;
    #1;
    chk("rst_en_out", int'(en_out), 0);
    chk("rst_up_out", int'(up_out), 0);
    chk("rst_load_out", int'(load_out), 0);
    chk("rst_syn_clr_out", int'(syn_clr_out), 0);
    chk("rst_d_out", int'(d_out), 0);
    chk("rst_err_flag", int'(err_flag), 0);
    exp_q.delete(); errset.delete(); clrat.delete();
    next_free = 0; exp_err = 1'b0; last_up = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    hold(m_ab, m_idx, 20);
  endtask

  int mon_np, mon_kind;
  ev_t mon_e;

  always @(negedge clk) begin
    if (mon_en) begin
      mon_np = int'(en_out) + int'(load_out) + int'(syn_clr_out);
      if (mon_np > 1) chk("one_command_per_cycle", mon_np, 1);
      if (mon_np >= 1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_pulse", cyc, -1);
        end else begin
          mon_e    = exp_q.pop_front();
          mon_kind = en_out ? 0 : (load_out ? 1 : 2);
          chk("pulse_kind", mon_kind, mon_e.kind);
          chk("pulse_cycle", cyc, mon_e.t);
          if (mon_e.kind == 0) begin
            chk("up_out", int'(up_out), int'(mon_e.up));
            last_up = mon_e.up;
          end
          if (mon_e.kind == 1) chk("d_out", int'(d_out), int'(mon_e.d));
        end
      end else begin
        if (exp_q.size() > 0 && exp_q[0].t < cyc) begin
          chk("missing_pulse", cyc, exp_q[0].t);
          void'(exp_q.pop_front());
        end
        chk("up_out_hold", int'(up_out), int'(last_up));
      end
      if (errset.exists(cyc))         exp_err = 1'b1;
      else if (clrat.exists(cyc - 1)) exp_err = 1'b0;
      chk("err_flag", int'(err_flag), int'(exp_err));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [1:0] nab;
  logic       nidx;
  int         r, h;

  initial begin
    rst_n = 1'b0; a_in = 1'b0; b_in = 1'b0; idx_in = 1'b0; err_clr = 1'b0;
    idx_mode = 1'b0; preset_val = '0; mon_en = 1'b0;
    m_ab = 2'b00; m_idx = 1'b0; exp_err = 1'b0; last_up = 1'b0;
    repeat (2) @(posedge clk);
    do_reset();

    // Up then down sequences
    hold(2'b01, 1'b0, 5); hold(2'b11, 1'b0, 5); hold(2'b10, 1'b0, 5); hold(2'b00, 1'b0, 5);
    hold(2'b10, 1'b0, 5); hold(2'b11, 1'b0, 5); hold(2'b01, 1'b0, 5); hold(2'b00, 1'b0, 5);

    // Illegal jump, clear, then a jump coinciding with err_clr
    hold(2'b11, 1'b0, 6);
    cyc_step(2'b11, 1'b0, 1'b1);
    hold(2'b11, 1'b0, 3);
    cyc_step(2'b00, 1'b0, 1'b0);
    hold(2'b00, 1'b0, L - 2);
    cyc_step(2'b00, 1'b0, 1'b1);
    hold(2'b00, 1'b0, 5);
    cyc_step(2'b00, 1'b0, 1'b1);
    hold(2'b00, 1'b0, 3);

    // Index as load, then as syn_clr
    set_cfg(1'b1, 8'hA5);
    hold(2'b00, 1'b1, 5); hold(2'b00, 1'b0, 5);
    set_cfg(1'b0, 8'h3C);
    hold(2'b00, 1'b1, 5); hold(2'b00, 1'b0, 5);

    // Index and step in the same sample cycle
    set_cfg(1'b1, 8'h5A);
    hold(2'b01, 1'b1, 5); hold(2'b01, 1'b0, 5);

`ifdef GLITCH_FILTER_EN
    // Short glitch on A must be swallowed by the filter
    @(posedge clk); #1; a_in = ~m_ab[1];
    @(posedge clk); #1;
    @(posedge clk); #1; a_in = m_ab[1];
    hold(m_ab, m_idx, L + 5);
`endif

    // Random traffic with a reset in the middle
    for (int s = 0; s < 300; s++) begin
      r = $urandom_range(0, 99);
      if (r < 35)      nab = abv[(gp[m_ab] + 1) % 4];
      else if (r < 70) nab = abv[(gp[m_ab] + 3) % 4];
      else if (r < 88) nab = m_ab;
      else             nab = abv[(gp[m_ab] + 2) % 4];
      nidx = ($urandom_range(0, 99) < 30) ? ~m_idx : m_idx;
      h = $urandom_range(MINH, MINH + 3);
      for (int k = 0; k < h; k++) cyc_step(nab, nidx, $urandom_range(0, 99) < 5);
      if (s == 150) do_reset();
      if (s % 60 == 59) set_cfg(1'($urandom_range(0, 1)), N'($urandom));
    end

    hold(m_ab, m_idx, L + 5);
    chk("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
